cache_ctrl: RTL and testbench

Cache management unit between the CPU data port and main memory.
- Instantiates the team's 2-way set-associative data array (`cache`) and sequences it: lookup, dirty-victim write-back, 4-word line refill, replay.
- CPU sees a single request/stall interface; memory sees a word-wide req/ack bus.

---
 rtl/cache_ctrl_pkg.sv | 65 ++++++
 rtl/cache.sv | 71 +++++++
 rtl/cache_ctrl.sv | 138 +++++++++++++
 tb/tb_cache_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared geometry, FSM states and RV32I load/store width encodings for the
// cache controller and its data array.
package cache_ctrl_pkg;

  localparam int ADDR_BITS           = 32;
  localparam int WORD_BITS           = 32;
  localparam int LINE_WORDS          = 4;
  localparam int WORD_BYTES_WIDTH    = 2;
  localparam int ELEMENT_WORDS_WIDTH = 2;
  localparam int SET_INDEX_WIDTH     = 5;
  localparam int TAG_BITS            = ADDR_BITS - SET_INDEX_WIDTH - ELEMENT_WORDS_WIDTH - WORD_BYTES_WIDTH;
  localparam int ELEMENT_NUM         = 1 << SET_INDEX_WIDTH;
  localparam int ELEMENT_WORDS       = LINE_WORDS;

  localparam int WORD_LSB = WORD_BYTES_WIDTH;
  localparam int IDX_LSB  = WORD_LSB + ELEMENT_WORDS_WIDTH;
  localparam int TAG_LSB  = IDX_LSB + SET_INDEX_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TAG      = 3'd1,
    S_PRE_BACK = 3'd2,
    S_BACK     = 3'd3,
    S_FILL     = 3'd4,
    S_WAIT     = 3'd5
  } state_e;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  function automatic logic [WORD_BITS-1:0] load_align(input logic [WORD_BITS-1:0] word,
                                                      input logic [1:0] off,
                                                      input logic [2:0] fn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (fn)
      F_B:     return {{24{b[7]}}, b};
      F_H:     return {{16{h[15]}}, h};
      F_BU:    return {24'd0, b};
      F_HU:    return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [WORD_BITS-1:0] store_merge(input logic [WORD_BITS-1:0] old,
                                                       input logic [WORD_BITS-1:0] wdata,
                                                       input logic [1:0] off,
                                                       input logic [2:0] fn);
    logic [WORD_BITS-1:0] r;
    r = old;
    case (fn)
      F_B: r[{off, 3'b000} +: 8] = wdata[7:0];
      F_H: if (off[1]) r[31:16] = wdata[15:0];
           else        r[15:0]  = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cache.sv
// 2-way set-associative data array with one LRU bit per set. All outputs are
// registered: a lookup driven in one cycle is visible the next.
module cache
  import cache_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [WORD_BITS-1:0] din_i,
  input  logic [2:0]           fn_i,
  input  logic                 load_i,
  input  logic                 edit_i,
  input  logic                 store_i,
  input  logic                 invalid_i,
  output logic                 hit_o,
  output logic [WORD_BITS-1:0] dout_o,
  output logic                 valid_o,
  output logic                 dirty_o,
  output logic [TAG_BITS-1:0]  tag_o
);

  logic [WORD_BITS-1:0]   data_q [2][ELEMENT_NUM][ELEMENT_WORDS];
  logic [TAG_BITS-1:0]    tag_q  [2][ELEMENT_NUM];
  logic [ELEMENT_NUM-1:0] valid_q [2];
  logic [ELEMENT_NUM-1:0] dirty_q [2];
  logic [ELEMENT_NUM-1:0] lru_q;

  logic [SET_INDEX_WIDTH-1:0]     idx;
  logic [ELEMENT_WORDS_WIDTH-1:0] wsel;
  logic [WORD_BYTES_WIDTH-1:0]    off;
  logic [TAG_BITS-1:0]            atag;
  logic                           hit0, hit1, any_hit, hway, vway;

  assign idx     = addr_i[TAG_LSB-1:IDX_LSB];
  assign wsel    = addr_i[IDX_LSB-1:WORD_LSB];
  assign off     = addr_i[WORD_LSB-1:0];
  assign atag    = addr_i[ADDR_BITS-1:TAG_LSB];
  assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == atag);
  assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == atag);
  assign any_hit = hit0 | hit1;
  assign hway    = hit1;
  // The LRU bit names the way to replace next.
  assign vway    = lru_q[idx];

  // NOTE: the array has no reset; a large RAM cannot be cleared in one cycle
  // and the controller's reset must not disturb cached lines anyway.
  always_ff @(posedge clk) begin
    hit_o   <= (load_i | edit_i) & any_hit;
    dout_o  <= load_i ? load_align(data_q[hway][idx][wsel], off, fn_i)
                      : data_q[vway][idx][wsel];
    tag_o   <= tag_q[vway][idx];
    valid_o <= valid_q[vway][idx];
    dirty_o <= dirty_q[vway][idx];

    if (invalid_i) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
    end else if ((load_i | edit_i) && any_hit) begin
      lru_q[idx] <= ~hway;
      if (edit_i) begin
        data_q[hway][idx][wsel] <= store_merge(data_q[hway][idx][wsel], din_i, off, fn_i);
        dirty_q[hway][idx]      <= 1'b1;
      end
    end else if (store_i) begin
      data_q[vway][idx][wsel] <= din_i;
      tag_q[vway][idx]        <= atag;
      valid_q[vway][idx]      <= 1'b1;
      dirty_q[vway][idx]      <= 1'b0;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Cache controller: sequences lookup, dirty write-back, 4-word refill and
// replay around the 2-way data array; CPU sees a request/stall handshake.
module cache_ctrl
  import cache_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_r,
  input  logic                 en_w,
  input  logic [2:0]           u_b_h_w,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_BITS-1:0] data_w,
  output logic [WORD_BITS-1:0] data_r,
  output logic                 stall,
  output logic                 mem_cs_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [WORD_BITS-1:0] mem_data_o,
  input  logic [WORD_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  state_e                         state_q, state_d;
  logic [ELEMENT_WORDS_WIDTH-1:0] cnt_q, cnt_d;
  logic [TAG_BITS-1:0]            victim_tag_q, victim_tag_d;
  logic                           victim_dirty_q, victim_dirty_d;
  logic [WORD_BITS-1:0]           data_r_q, data_r_d;

  logic                           req, tag_hit, use_cnt;
  logic                           arr_load, arr_edit, arr_store;
  logic                           arr_hit, arr_valid, arr_dirty;
  logic [WORD_BITS-1:0]           arr_dout;
  logic [TAG_BITS-1:0]            arr_tag;
  logic [ADDR_BITS-1:0]           arr_addr;
  logic [SET_INDEX_WIDTH-1:0]     index;

  assign req     = en_r | en_w;
  assign index   = addr[TAG_LSB-1:IDX_LSB];
  assign tag_hit = (state_q == S_TAG) && arr_hit;
  assign stall   = req & ~tag_hit;
  assign data_r  = tag_hit ? arr_dout : data_r_q;

  // S_BACK also uses cnt so the victim word on dout holds steady until ack.
  assign use_cnt  = (state_q == S_PRE_BACK) || (state_q == S_BACK) || (state_q == S_FILL);
  assign arr_addr = {addr[ADDR_BITS-1:IDX_LSB], use_cnt ? cnt_q : addr[IDX_LSB-1:WORD_LSB],
                     addr[WORD_LSB-1:0]};

  cache u_cache (
    .clk       (clk),
    .addr_i    (arr_addr),
    .din_i     (state_q == S_FILL ? mem_data_i : data_w),
    .fn_i      (u_b_h_w),
    .load_i    (arr_load),
    .edit_i    (arr_edit),
    .store_i   (arr_store),
    .invalid_i (1'b0),
    .hit_o     (arr_hit),
    .dout_o    (arr_dout),
    .valid_o   (arr_valid),
    .dirty_o   (arr_dirty),
    .tag_o     (arr_tag)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    victim_tag_d   = victim_tag_q;
    victim_dirty_d = victim_dirty_q;
    data_r_d       = data_r_q;
    arr_load       = 1'b0;
    arr_edit       = 1'b0;
    arr_store      = 1'b0;
    mem_cs_o       = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = {addr[ADDR_BITS-1:IDX_LSB], cnt_q, 2'b00};
    mem_data_o     = arr_dout;

    case (state_q)
      S_IDLE: begin
        arr_load = en_r & ~en_w;
        arr_edit = en_w;
        if (req) state_d = S_TAG;
      end
      S_TAG: begin
        if (arr_hit) begin
          data_r_d = arr_dout;
          state_d  = S_IDLE;
        end else begin
          victim_tag_d   = arr_tag;
          victim_dirty_d = arr_valid & arr_dirty;
          cnt_d          = '0;
          state_d        = (arr_valid & arr_dirty) ? S_PRE_BACK : S_FILL;
        end
      end
      S_PRE_BACK: state_d = S_BACK;
      S_BACK: begin
        mem_cs_o   = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {victim_tag_q, index, cnt_q, 2'b00};
        if (mem_ack_i) begin
          cnt_d   = cnt_q + 2'd1;
          state_d = (cnt_q == 2'd3) ? S_FILL : S_PRE_BACK;
        end
      end
      S_FILL: begin
        mem_cs_o  = 1'b1;
        arr_store = mem_ack_i;
        if (mem_ack_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_WAIT;
        end
      end
      S_WAIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      victim_tag_q   <= '0;
      victim_dirty_q <= 1'b0;
      data_r_q       <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      victim_tag_q   <= victim_tag_d;
      victim_dirty_q <= victim_dirty_d;
      data_r_q       <= data_r_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural cache/memory model.
module tb_cache_ctrl;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clk = 1'b0;
  logic        rst, en_r, en_w;
  logic [2:0]  u_b_h_w;
  logic [31:0] addr, data_w, data_r;
  logic        stall, mem_cs_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic        mem_ack_i;

  int checks = 0;
  int errors = 0;
  int lat    = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  xfer_t       log_q[$];
  xfer_t       exp_q[$];
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  logic [22:0] m_tag   [32][2];
  bit          m_valid [32][2];
  bit          m_dirty [32][2];
  bit          m_lru   [32];

  logic [2:0] ld_ops [5] = '{LB, LH, LW, LBU, LHU};
  logic [2:0] st_ops [3] = '{SB, SH, SW};

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .en_r       (en_r),
    .en_w       (en_w),
    .u_b_h_w    (u_b_h_w),
    .addr       (addr),
    .data_w     (data_w),
    .data_r     (data_r),
    .stall      (stall),
    .mem_cs_o   (mem_cs_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .mem_ack_i  (mem_ack_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a >= 32'h100 && a <= 32'h10C) return 32'hA0 + ((a - 32'h100) >> 2);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] f);
    logic [31:0]        w;
    logic signed [31:0] s;
    int                 sh;
    w  = ref_rd({a[31:2], 2'b00});
    sh = 8 * int'(a[1:0]);
    case (f)
      LB:      begin s = w << (24 - sh); return s >>> 24; end
      LH:      begin s = w << (16 - sh); return s >>> 16; end
      LBU:     return (w >> sh) & 32'hFF;
      LHU:     return (w >> sh) & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    logic [31:0] w, mask;
    int          sh;
    sh   = 8 * int'(a[1:0]);
    mask = (f == SB) ? 32'hFF : (f == SH) ? 32'hFFFF : 32'hFFFF_FFFF;
    w    = ref_rd({a[31:2], 2'b00});
    w    = (w & ~(mask << sh)) | ((d & mask) << sh);
    ref_mem[{a[31:2], 2'b00}] = w;
  endtask

  // Two-way LRU cache model: predicts hit/miss and the exact memory traffic.
  task automatic model_access(input logic [31:0] a, input bit is_store, output bit hit);
    logic [4:0]  ix;
    logic [22:0] tg;
    logic [31:0] la;
    int          h, v;
    ix = a[8:4];
    tg = a[31:9];
    h  = -1;
    for (int w = 0; w < 2; w++)
      if (m_valid[ix][w] && m_tag[ix][w] == tg) h = w;
    hit = (h >= 0);
    if (!hit) begin
      v = int'(m_lru[ix]);
      if (m_valid[ix][v] && m_dirty[ix][v])
        for (int k = 0; k < 4; k++) begin
          la = {m_tag[ix][v], ix, 2'(k), 2'b00};
          exp_q.push_back('{1'b1, la, ref_rd(la)});
        end
      for (int k = 0; k < 4; k++) begin
        la = {tg, ix, 2'(k), 2'b00};
        exp_q.push_back('{1'b0, la, ref_rd(la)});
      end
      m_tag[ix][v]   = tg;
      m_valid[ix][v] = 1'b1;
      m_dirty[ix][v] = 1'b0;
      h = v;
    end
    m_lru[ix] = (h == 0);
    if (is_store) m_dirty[ix][h] = 1'b1;
  endtask

  // Memory responder: acks after `lat` wait cycles, checks bus stability while waiting.
  initial begin
    int    waited;
    xfer_t first;
    waited     = 0;
    first      = '0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk); #1;
      if (rst || mem_ack_i) begin
        mem_ack_i = 1'b0;
        waited    = 0;
      end else if (mem_cs_o) begin
        if (waited == 0) first = '{mem_we_o, mem_addr_o, mem_data_o};
        else begin
          check("mem_addr_stable", mem_addr_o, first.a);
          check("mem_we_stable", 32'(mem_we_o), 32'(first.we));
          if (first.we) check("mem_data_stable", mem_data_o, first.d);
        end
        if (waited >= lat) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) mem[mem_addr_o] = mem_data_o;
          else          mem_data_i = mem_rd(mem_addr_o);
          log_q.push_back('{mem_we_o, mem_addr_o, mem_we_o ? mem_data_o : mem_data_i});
        end else begin
          waited++;
        end
      end
    end
  end

  task automatic do_req(input string tag, input bit rd, input bit wr, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d);
    bit          hit;
    int          cyc;
    logic [31:0] exp_d;
    exp_d = '0;
    exp_q.delete();
    log_q.delete();
    model_access(a, wr, hit);
    if (!wr) exp_d = exp_load(a, f);
    else     ref_store(a, f, d);
    en_r = rd; en_w = wr; u_b_h_w = f; addr = a; data_w = d;
    #1;
    cyc = 0;
    while (stall === 1'b1 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 400) check({tag, "_timeout"}, 32'(cyc), 32'd0);
    if (!wr) check({tag, "_data"}, data_r, exp_d);
    if (hit) check({tag, "_hit_stall"}, 32'(cyc), 32'd1);
    @(posedge clk); #1;
    en_r = 1'b0; en_w = 1'b0;
    check({tag, "_nxfer"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check({tag, "_xfer_we"}, 32'(log_q[i].we), 32'(exp_q[i].we));
      check({tag, "_xfer_addr"}, log_q[i].a, exp_q[i].a);
      check({tag, "_xfer_data"}, log_q[i].d, exp_q[i].d);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          cyc;
    rst = 1'b1; en_r = 1'b0; en_w = 1'b0; u_b_h_w = '0; addr = '0; data_w = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_r", data_r, 32'h0);
    check("rst_mem_cs", 32'(mem_cs_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_req("cold_lw", 1, 0, LW, 32'h104, 0);
    check("cold_lw_val", data_r, 32'hA1);
    check("cold_lw_nfill", 32'(log_q.size()), 32'd4);
    do_req("hit_lw", 1, 0, LW, 32'h104, 0);
    check("hit_lw_val", data_r, 32'hA1);
    do_req("sb_105", 0, 1, SB, 32'h105, 32'h55);
    do_req("lbu_105", 1, 0, LBU, 32'h105, 0);
    check("lbu_105_val", data_r, 32'h55);
    do_req("sb_107", 0, 1, SB, 32'h107, 32'h80);
    do_req("lb_107", 1, 0, LB, 32'h107, 0);
    check("lb_107_val", data_r, 32'hFFFF_FF80);
    do_req("lw_2100", 1, 0, LW, 32'h2100, 0);
    do_req("lw_4100", 1, 0, LW, 32'h4100, 0);
    check("wb_104_mem", mem_rd(32'h104), 32'h8000_55A1);

    lat = 5;
    do_req("slow_lw_8200", 1, 0, LW, 32'h8200, 0);
    do_req("slow_rw_8204", 1, 1, SW, 32'h8204, 32'h1234_5678);
    do_req("slow_lw_a200", 1, 0, LW, 32'hA200, 0);
    do_req("slow_lw_c200", 1, 0, LW, 32'hC200, 0);
    check("wb_8204_mem", mem_rd(32'h8204), 32'h1234_5678);

    for (int n = 0; n < 150; n++) begin
      logic [22:0] tg;
      logic [4:0]  ix;
      logic [1:0]  wd, by;
      logic [2:0]  f;
      bit          rd, wr;
      lat = $urandom_range(0, 2);
      tg  = 23'h40 + 23'($urandom_range(0, 2));
      ix  = 5'($urandom_range(2, 3));
      wd  = 2'($urandom_range(0, 3));
      by  = 2'($urandom_range(0, 3));
      wr  = ($urandom_range(0, 2) == 0);
      if (wr) begin
        f  = st_ops[$urandom_range(0, 2)];
        rd = ($urandom_range(0, 3) == 0);
      end else begin
        f  = ld_ops[$urandom_range(0, 4)];
        rd = 1'b1;
      end
      if (f[1:0] == 2'b01) by = {by[1], 1'b0};
      else if (f[1:0] == 2'b10) by = 2'b00;
      do_req("rand", rd, wr, f, {tg, ix, wd, by}, $urandom);
    end

    // Reset while the third refill word is outstanding.
    lat = 4;
    a   = 32'h3650;
    log_q.delete();
    en_r = 1'b1; u_b_h_w = LW; addr = a;
    cyc = 0;
    while (!(log_q.size() == 2 && mem_cs_o === 1'b1 && mem_ack_i === 1'b0) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_mid_fill_words", 32'(log_q.size()), 32'd2);
    en_r = 1'b0;
    rst  = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_mem_cs", 32'(mem_cs_o), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    log_q.delete();
    en_r = 1'b1; addr = a;
    #1;
    cyc = 0;
    while (stall === 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("partial_line_hit_stall", 32'(cyc), 32'd1);
    check("partial_line_data", data_r, mem_rd(a));
    @(posedge clk); #1;
    en_r = 1'b0;
    check("partial_line_nxfer", 32'(log_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
